dvi_video_gen: RTL and testbench

- Parametrised video timing and pattern generator that drives the Black Mesa Labs HDMI PMOD (TFP410) in either 3b or 12b colour mode.
- Successor to the fixed 640x480 timing core. Adds:
  - generic timing parameters and sync polarity,
  - selectable output colour depth,
  - four pattern modes, including an external pixel source with a request handshake,
  - frame-synchronous mode switching and a frame counter.
- Sits between the PLL pixel clock and the PMOD pin assignment in the top level.

---
 rtl/dvi_video_gen.sv | 182 ++++++++++++++++++
 tb/tb_dvi_video_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dvi_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : dvi_video_gen
// Summary  : Parametrised video timing and test-pattern generator for the
//            TFP410 HDMI PMOD (3b or 12b colour).
// Revision : 1.0 - initial release
// ============================================================================
module dvi_video_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   OUT_BITS = 4
) (
   input  logic                clk_dot,
   input  logic                reset,
   input  logic [1:0]          mode,
   input  logic [23:0]         ext_rgb,
   output logic                ext_req,
   output logic                frame_start,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] hcount,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] vcount,
   output logic                vga_de,
   output logic                vga_hs,
   output logic                vga_vs,
   output logic [OUT_BITS-1:0] pix_r,
   output logic [OUT_BITS-1:0] pix_g,
   output logic [OUT_BITS-1:0] pix_b
);

   localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);
   localparam int BAR_W  = H_ACTIVE / 8;

   localparam logic [HW-1:0] c_h_last   = HW'(HTOTAL - 1);
   localparam logic [VW-1:0] c_v_last   = VW'(VTOTAL - 1);
   localparam logic [HW-1:0] c_bar_last = HW'(BAR_W - 1);
   localparam logic [31:0]   c_h_act    = H_ACTIVE;
   localparam logic [31:0]   c_v_act    = V_ACTIVE;
   localparam logic [31:0]   c_hs_start = H_ACTIVE + H_FP;
   localparam logic [31:0]   c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
   localparam logic [31:0]   c_vs_start = V_ACTIVE + V_FP;
   localparam logic [31:0]   c_vs_end   = V_ACTIVE + V_FP + V_SYNC;

   logic [HW-1:0] r_hc;
   logic [VW-1:0] r_vc;
   logic [1:0]    r_mode;
   logic [7:0]    r_frame_cnt;
   logic [HW-1:0] r_bar_cnt;
   logic [2:0]    r_bar_idx;

   logic [31:0] w_h32;
   logic [31:0] w_v32;
   logic        w_h_wrap;
   logic        w_frame_wrap;
   logic        w_frame_first;
   logic        w_active;
   logic        w_hs_on;
   logic        w_vs_on;
   logic        w_checker;
   logic [1:0]  w_mode;
   logic [7:0]  w_r;
   logic [7:0]  w_g;
   logic [7:0]  w_b;
   logic        w_unused_bits;

   assign w_h32         = 32'(r_hc);
   assign w_v32         = 32'(r_vc);
   assign w_h_wrap      = (r_hc == c_h_last);
   assign w_frame_wrap  = w_h_wrap && (r_vc == c_v_last);
   assign w_frame_first = (r_hc == '0) && (r_vc == '0);
   assign w_active      = (w_h32 < c_h_act) && (w_v32 < c_v_act);
   assign w_hs_on       = (w_h32 >= c_hs_start) && (w_h32 < c_hs_end);
   assign w_vs_on       = (w_v32 >= c_vs_start) && (w_v32 < c_vs_end);
   assign w_checker     = w_h32[5] ^ w_v32[5];
   assign ext_req       = w_active;

   // The first pixel of a frame already shows the mode being latched on it.
   assign w_mode = w_frame_first ? mode : r_mode;

   always_ff @(posedge clk_dot) begin
      if (reset) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_h_wrap) begin
         r_hc <= '0;
         r_vc <= (r_vc == c_v_last) ? '0 : r_vc + 1'b1;
      end else begin
         r_hc <= r_hc + 1'b1;
      end
   end

   // Bar index tracks hc with a width counter so no divider is needed.
   always_ff @(posedge clk_dot) begin
      if (reset || w_h_wrap) begin
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
      end else if (w_h32 < c_h_act) begin
         if (r_bar_cnt == c_bar_last) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 1'b1;
         end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_dot) begin
      if (reset) begin
         r_mode      <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (w_frame_first) r_mode <= mode;
         if (w_frame_wrap)  r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      case (w_mode)
         2'd0: begin
            w_r = {8{~r_bar_idx[1]}};
            w_g = {8{~r_bar_idx[2]}};
            w_b = {8{~r_bar_idx[0]}};
         end
         2'd1: begin
            w_r = {8{w_checker}};
            w_g = {8{w_checker}};
            w_b = {8{w_checker}};
         end
         2'd2: begin
            w_r = w_h32[7:0];
            w_g = w_v32[7:0];
            w_b = r_frame_cnt;
         end
         default: begin
            w_r = ext_rgb[23:16];
            w_g = ext_rgb[15:8];
            w_b = ext_rgb[7:0];
         end
      endcase
   end

   // Low channel bits are dropped by packing when OUT_BITS < 8.
   assign w_unused_bits = &{1'b0, w_r, w_g, w_b};

   always_ff @(posedge clk_dot) begin
      if (reset) begin
         vga_de      <= 1'b0;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         frame_start <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         pix_r       <= '0;
         pix_g       <= '0;
         pix_b       <= '0;
      end else begin
         vga_de      <= w_active;
         vga_hs      <= w_hs_on ? HS_POL : ~HS_POL;
         vga_vs      <= w_vs_on ? VS_POL : ~VS_POL;
         frame_start <= w_frame_first;
         hcount      <= r_hc;
         vcount      <= r_vc;
         pix_r       <= w_active ? w_r[7 -: OUT_BITS] : '0;
         pix_g       <= w_active ? w_g[7 -: OUT_BITS] : '0;
         pix_b       <= w_active ? w_b[7 -: OUT_BITS] : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dvi_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvi_video_gen
// Summary  : Self-checking bench for dvi_video_gen (12b active-low instance
//            plus a 3b instance with active-high hsync).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvi_video_gen;

   localparam int HT = 24;
   localparam int VT = 12;
   localparam int FT = HT * VT;

   logic        clk_dot = 1'b0;
   logic        reset   = 1'b1;
   logic [1:0]  mode    = 2'd0;
   logic [23:0] ext_rgb = 24'd0;

   logic       ext_req, frame_start, vga_de, vga_hs, vga_vs;
   logic [4:0] hcount;
   logic [3:0] vcount;
   logic [3:0] pix_r, pix_g, pix_b;

   logic       b_ext_req, b_frame_start, b_de, b_hs, b_vs;
   logic [4:0] b_hcount;
   logic [3:0] b_vcount;
   logic [0:0] b_r, b_g, b_b;

   int checks   = 0;
   int failures = 0;
   int p        = 0;
   logic [1:0] mq = 2'd0;

   always #5 clk_dot = ~clk_dot;

   dvi_video_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .OUT_BITS(4)
   ) u_dut (
      .clk_dot(clk_dot), .reset(reset), .mode(mode), .ext_rgb(ext_rgb),
      .ext_req(ext_req), .frame_start(frame_start), .hcount(hcount),
      .vcount(vcount), .vga_de(vga_de), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
   );

   dvi_video_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .OUT_BITS(1)
   ) u_dut_b (
      .clk_dot(clk_dot), .reset(reset), .mode(mode), .ext_rgb(ext_rgb),
      .ext_req(b_ext_req), .frame_start(b_frame_start), .hcount(b_hcount),
      .vcount(b_vcount), .vga_de(b_de), .vga_hs(b_hs), .vga_vs(b_vs),
      .pix_r(b_r), .pix_g(b_g), .pix_b(b_b)
   );

   typedef struct {
      logic [1:0]  mode;
      logic        exp_de;
      logic        exp_hs;
      logic [11:0] exp_rgb;
      logic [2:0]  exp_rgb_b;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (p=%0d)", nm, act, exp, p);
      end
   endtask

   function automatic logic [23:0] m_rgb(input int h, input int v, input int fc,
                                         input logic [1:0] md, input logic [23:0] ext);
      logic [23:0] c;
      c = 24'h0;
      case (md)
         2'd0: case (h / 2)
                  0: c = 24'hFFFFFF;
                  1: c = 24'hFFFF00;
                  2: c = 24'h00FFFF;
                  3: c = 24'h00FF00;
                  4: c = 24'hFF00FF;
                  5: c = 24'hFF0000;
                  6: c = 24'h0000FF;
                  default: c = 24'h000000;
               endcase
         2'd1: c = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
         2'd2: c = {8'(h), 8'(v), 8'(fc)};
         default: c = ext;
      endcase
      return c;
   endfunction

   // One clock: predict from the frame position p, step, then compare.
   task automatic tick(input logic rst_in);
      int h, v, fc;
      logic act, hs_on, vs_on;
      logic [1:0] md;
      logic [23:0] c;
      reset = rst_in;
      h  = p % HT;
      v  = (p / HT) % VT;
      fc = (p / FT) % 256;
      act   = (h < 16) && (v < 8);
      hs_on = (h >= 18) && (h < 21);
      vs_on = (v >= 9) && (v < 11);
      chk("ext_req", 32'(ext_req), 32'(act));
      chk("ext_req_b", 32'(b_ext_req), 32'(act));
      md = (p % FT == 0) ? mode : mq;
      c  = act ? m_rgb(h, v, fc, md, ext_rgb) : 24'h0;
      @(posedge clk_dot);
      #1;
      if (rst_in) begin
         chk("rst_de", 32'(vga_de), 0);
         chk("rst_hs", 32'(vga_hs), 1);
         chk("rst_vs", 32'(vga_vs), 1);
         chk("rst_fs", 32'(frame_start), 0);
         chk("rst_pos", {hcount, vcount}, 0);
         chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
         chk("rst_b", {b_de, b_hs, b_vs, b_r, b_g, b_b}, 32'b001000);
         p  = 0;
         mq = 2'd0;
      end else begin
         chk("de", 32'(vga_de), 32'(act));
         chk("hs", 32'(vga_hs), 32'(!hs_on));
         chk("vs", 32'(vga_vs), 32'(!vs_on));
         chk("fs", 32'(frame_start), 32'(p % FT == 0));
         chk("hcount", 32'(hcount), 32'(h));
         chk("vcount", 32'(vcount), 32'(v));
         chk("pix", {pix_r, pix_g, pix_b}, {c[23:20], c[15:12], c[7:4]});
         chk("b_sync", {b_de, b_hs, b_vs, b_frame_start}, {act, hs_on, !vs_on, p % FT == 0});
         chk("b_pix", {b_r, b_g, b_b}, {c[23], c[15], c[7]});
         mq = md;
         p++;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [24];
      int q, f, r;
      tbl = '{
         '{2'd0, 1'b1, 1'b1, 12'hFFF, 3'd7}, '{2'd0, 1'b1, 1'b1, 12'hFFF, 3'd7},
         '{2'd0, 1'b1, 1'b1, 12'hFF0, 3'd6}, '{2'd0, 1'b1, 1'b1, 12'hFF0, 3'd6},
         '{2'd0, 1'b1, 1'b1, 12'h0FF, 3'd3}, '{2'd0, 1'b1, 1'b1, 12'h0FF, 3'd3},
         '{2'd0, 1'b1, 1'b1, 12'h0F0, 3'd2}, '{2'd0, 1'b1, 1'b1, 12'h0F0, 3'd2},
         '{2'd0, 1'b1, 1'b1, 12'hF0F, 3'd5}, '{2'd0, 1'b1, 1'b1, 12'hF0F, 3'd5},
         '{2'd0, 1'b1, 1'b1, 12'hF00, 3'd4}, '{2'd0, 1'b1, 1'b1, 12'hF00, 3'd4},
         '{2'd0, 1'b1, 1'b1, 12'h00F, 3'd1}, '{2'd0, 1'b1, 1'b1, 12'h00F, 3'd1},
         '{2'd0, 1'b1, 1'b1, 12'h000, 3'd0}, '{2'd0, 1'b1, 1'b1, 12'h000, 3'd0},
         '{2'd0, 1'b0, 1'b1, 12'h000, 3'd0}, '{2'd0, 1'b0, 1'b1, 12'h000, 3'd0},
         '{2'd0, 1'b0, 1'b0, 12'h000, 3'd0}, '{2'd0, 1'b0, 1'b0, 12'h000, 3'd0},
         '{2'd0, 1'b0, 1'b0, 12'h000, 3'd0}, '{2'd0, 1'b0, 1'b1, 12'h000, 3'd0},
         '{2'd0, 1'b0, 1'b1, 12'h000, 3'd0}, '{2'd0, 1'b0, 1'b1, 12'h000, 3'd0}
      };

      repeat (2) @(posedge clk_dot);
      #1;
      tick(1'b1);

      // Line 0 of frame 0 in colour-bar mode, against the literal table.
      for (int i = 0; i < 24; i++) begin
         mode = tbl[i].mode;
         tick(1'b0);
         chk("tbl_de", 32'(vga_de), 32'(tbl[i].exp_de));
         chk("tbl_hs", 32'(vga_hs), 32'(tbl[i].exp_hs));
         chk("tbl_fs", 32'(frame_start), 32'(i == 0));
         chk("tbl_pix", {pix_r, pix_g, pix_b}, 32'(tbl[i].exp_rgb));
         chk("tbl_pix_b", {b_r, b_g, b_b}, 32'(tbl[i].exp_rgb_b));
         chk("tbl_hs_b", 32'(b_hs), 32'(!tbl[i].exp_hs));
      end

      // Mid-frame reset at hc=7, vc=4 held for two cycles.
      while (p != 4 * HT + 7) tick(1'b0);
      tick(1'b1);
      chk("midrst_de", 32'(vga_de), 0);
      chk("midrst_hsvs", {vga_hs, vga_vs}, 32'b11);
      tick(1'b1);
      chk("midrst_hsb", 32'(b_hs), 0);
      tick(1'b0);
      chk("restart_fs", 32'(frame_start), 1);
      chk("restart_pos", {hcount, vcount, vga_de}, 32'b1);
      chk("restart_pix", {pix_r, pix_g, pix_b}, 32'hFFF);

      // Long randomized run covering mode switches, external pixels and
      // the 8-bit frame counter wrap.
      while (p <= 256 * FT + 2) begin
         f = p / FT;
         r = p % FT;
         if (f == 1 && r == 3 * HT) mode = 2'd2;
         if (f == 2 && r == 100) mode = 2'd3;
         if (f >= 4 && f < 14 && $urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
         if (f == 14 && r == 200) mode = 2'd2;
         ext_rgb = 24'($urandom);
         if (f == 3 && r == 2 * HT + 5) ext_rgb = 24'hA5C33C;
         tick(1'b0);
         q = p - 1;
         if (q == FT + 4 * HT)         chk("no_tear", {pix_r, pix_g, pix_b}, 32'hFFF);
         if (q == 2 * FT)              chk("grad_start", {pix_r, pix_g, pix_b}, 32'h000);
         if (q == 3 * FT + 2 * HT + 5) chk("ext_pix", {pix_r, pix_g, pix_b}, 32'hAC3);
         if (q == 3 * FT + 2 * HT + 20) chk("ext_blank", {vga_de, pix_r, pix_g, pix_b}, 0);
         if (q == 16 * FT)             chk("grad_b16", {pix_r, pix_g, pix_b}, 32'h001);
         if (q == 255 * FT)            chk("grad_b255", {pix_r, pix_g, pix_b}, 32'h00F);
         if (q == 256 * FT)            chk("grad_wrap", {pix_r, pix_g, pix_b}, 32'h000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
